// File: rtl/ram_block_pkg.sv
// Shared encodings for the RAM block engine: command opcodes and FSM states.
package ram_block_pkg;

  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    CP_RD    = 3'd2,
    CP_WR    = 3'd3,
    SUM_RD   = 3'd4,
    SUM_LAST = 3'd5,
    DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/ram_block_engine.sv
// Bulk memory engine driving a single-port synchronous RAM: FILL, COPY and
// 8-bit additive CHECKSUM over a wrapping address region, one command at a time.
module ram_block_engine
  import ram_block_pkg::*;
#(
  parameter int ram_width = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Command handshake: a command is taken on the rising edge where
  // cmd_valid && cmd_ready; cmd_ready is high only while idle.
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ram_width-1:0] cmd_src,
  input  logic [ram_width-1:0] cmd_dst,
  input  logic [ram_width:0]   cmd_len,
  input  logic [7:0]           cmd_data,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           result,
  output logic                 ram_rw,
  output logic [ram_width-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  output state_t               state_dbg
);

  localparam logic [ram_width:0]   LEN_ONE  = (ram_width+1)'(1);
  localparam logic [ram_width-1:0] ADDR_ONE = ram_width'(1);

  state_t               state;
  logic [ram_width-1:0] src_ptr;
  logic [ram_width-1:0] dst_ptr;
  logic [ram_width:0]   cnt;
  logic [7:0]           fill_q;
  logic [7:0]           acc;
  logic                 rd_pend;

  assign state_dbg = state;
  // A copy write forwards the byte read in the preceding CP_RD cycle.
  assign ram_wdata = (state == CP_WR) ? ram_rdata : fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      cnt       <= '0;
      fill_q    <= '0;
      acc       <= '0;
      rd_pend   <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      ram_rw    <= 1'b0;
      ram_addr  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            src_ptr   <= cmd_src;
            dst_ptr   <= cmd_dst;
            cnt       <= cmd_len;
            fill_q    <= cmd_data;
            acc       <= '0;
            rd_pend   <= 1'b0;
            if (cmd_len == '0 || cmd_op == OP_NOP) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (cmd_op == OP_FILL) begin
              state    <= FILL;
              ram_rw   <= 1'b1;
              ram_addr <= cmd_dst;
            end else if (cmd_op == OP_COPY) begin
              state    <= CP_RD;
              ram_addr <= cmd_src;
            end else begin
              state    <= SUM_RD;
              ram_addr <= cmd_src;
            end
          end
        end
        FILL: begin
          if (cnt == LEN_ONE) begin
            state  <= DONE;
            done   <= 1'b1;
            ram_rw <= 1'b0;
          end else begin
            cnt      <= cnt - LEN_ONE;
            dst_ptr  <= dst_ptr + ADDR_ONE;
            ram_addr <= dst_ptr + ADDR_ONE;
          end
        end
        CP_RD: begin
          state    <= CP_WR;
          ram_rw   <= 1'b1;
          ram_addr <= dst_ptr;
        end
        CP_WR: begin
          ram_rw <= 1'b0;
          if (cnt == LEN_ONE) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= CP_RD;
            cnt      <= cnt - LEN_ONE;
            src_ptr  <= src_ptr + ADDR_ONE;
            dst_ptr  <= dst_ptr + ADDR_ONE;
            ram_addr <= src_ptr + ADDR_ONE;
          end
        end
        SUM_RD: begin
          // Read data lags the address by one cycle, so the first read adds nothing.
          if (rd_pend) acc <= acc + ram_rdata;
          rd_pend <= 1'b1;
          if (cnt == LEN_ONE) begin
            state <= SUM_LAST;
          end else begin
            cnt      <= cnt - LEN_ONE;
            src_ptr  <= src_ptr + ADDR_ONE;
            ram_addr <= src_ptr + ADDR_ONE;
          end
        end
        SUM_LAST: begin
          result <= acc + ram_rdata;
          state  <= DONE;
          done   <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_block_engine.sv
// Bench for ram_block_engine: behavioural RAM responder, array-level reference
// model, directed test-plan commands plus randomized commands.
module tb_ram_block_engine;
  import ram_block_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [AW:0]   cmd_len = '0;
  logic [7:0]    cmd_data = '0;
  logic          busy, done;
  logic [7:0]    result;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  state_t        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]      mem     [DEPTH];
  logic [7:0]      ref_mem [DEPTH];
  logic [AW+7:0]   wr_q[$];
  logic [AW+7:0]   exp_q[$];
  logic [7:0]      exp_result = '0;

  ram_block_engine #(.ram_width(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .busy(busy), .done(done), .result(result),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .state_dbg(state_dbg)
  );

  // clock / RAM responder / write monitor
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rw) mem[ram_addr] = ram_wdata;
    else        ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (rst_n && ram_rw) wr_q.push_back({ram_addr, ram_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int addr, input logic [7:0] val);
    mem[addr[AW-1:0]]     = val;
    ref_mem[addr[AW-1:0]] = val;
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Reference model: operates on the whole array, produces expected writes,
  // checksum and completion latency.
  task automatic model_cmd(input logic [1:0] op, input logic [AW-1:0] src,
                           input logic [AW-1:0] dst, input int len,
                           input logic [7:0] data, output int lat);
    logic [AW-1:0] s, d;
    logic [7:0]    sum, b;
    s = src; d = dst; sum = '0;
    if (len == 0 || op == 2'b11) begin
      lat = 1;
    end else if (op == 2'b00) begin
      for (int i = 0; i < len; i++) begin
        ref_mem[d] = data; exp_q.push_back({d, data}); d = d + 1'b1;
      end
      lat = len + 1;
    end else if (op == 2'b01) begin
      for (int i = 0; i < len; i++) begin
        b = ref_mem[s]; ref_mem[d] = b; exp_q.push_back({d, b});
        s = s + 1'b1; d = d + 1'b1;
      end
      lat = 2 * len + 1;
    end else begin
      for (int i = 0; i < len; i++) begin
        sum = sum + ref_mem[s]; s = s + 1'b1;
      end
      exp_result = sum;
      lat = len + 2;
    end
  endtask

  // Driver: issues one command, keeps cmd_valid high with junk fields while
  // busy, measures acceptance-to-done latency, then scoreboards everything.
  task automatic run_cmd(input string name, input logic [1:0] op, input int src,
                         input int dst, input int len, input logic [7:0] data);
    int lat, cyc, busy_low, ready_high;
    bit seen;
    wr_q.delete(); exp_q.delete();
    model_cmd(op, src[AW-1:0], dst[AW-1:0], len, data, lat);
    cyc = 0;
    @(negedge clk);
    while (!cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
    check({name, " ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src[AW-1:0]; cmd_dst = dst[AW-1:0];
    cmd_len = len[AW:0]; cmd_data = data;
    @(posedge clk);
    cyc = 0; seen = 0; busy_low = 0; ready_high = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cmd_op = 2'($urandom); cmd_src = AW'($urandom); cmd_dst = AW'($urandom);
      cmd_len = (AW+1)'($urandom_range(1, 8)); cmd_data = 8'($urandom);
      if (!busy) busy_low++;
      if (cmd_ready) ready_high++;
      if (done) seen = 1;
    end
    cmd_valid = 1'b0;
    check({name, " latency"}, cyc, lat);
    check({name, " busy_low"}, busy_low, 0);
    check({name, " ready_while_busy"}, ready_high, 0);
    @(negedge clk);
    check({name, " post_done"}, {cmd_ready, busy, done}, 3'b100);
    check({name, " n_writes"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      check({name, " write"}, wr_q[i], exp_q[i]);
    check({name, " result"}, result, exp_result);
    check({name, " mem_diffs"}, mem_diffs(), 0);
  endtask

  initial begin
    int op, len, r;
    for (int i = 0; i < DEPTH; i++) preload(i, 8'($urandom));

    repeat (3) @(negedge clk);
    check("reset outs", {cmd_ready, busy, done, ram_rw}, 4'b1000);
    check("reset result", result, 0);
    check("reset addr", ram_addr, 0);
    check("reset wdata", ram_wdata, 0);
    check("reset state", state_dbg, IDLE);
    rst_n = 1'b1;

    run_cmd("fill", 2'b00, 'h010, 'h010, 4, 8'hA5);
    check("fill byte3", mem['h013], 8'hA5);

    preload('h100, 8'h01); preload('h101, 8'h02); preload('h102, 8'h03);
    run_cmd("copy", 2'b01, 'h100, 'h200, 3, 8'h00);
    check("copy bytes", {mem['h200], mem['h201], mem['h202]}, 24'h010203);

    preload('h300, 8'hFF); preload('h301, 8'h01); preload('h302, 8'h10); preload('h303, 8'h20);
    run_cmd("sum", 2'b10, 'h300, 0, 4, 8'h00);
    check("sum value", result, 8'h30);
    run_cmd("fill_after_sum", 2'b00, 0, 'h120, 2, 8'h77);
    check("sum held", result, 8'h30);

    run_cmd("fill_wrap", 2'b00, 0, 'h3FE, 4, 8'h5A);
    check("wrap bytes", {mem['h3FE], mem['h3FF], mem['h000], mem['h001]}, 32'h5A5A5A5A);
    run_cmd("fill_len0", 2'b00, 0, 'h040, 0, 8'hEE);
    run_cmd("nop", 2'b11, 'h040, 'h080, 5, 8'hEE);
    run_cmd("copy_overlap", 2'b01, 'h060, 'h061, 5, 8'h00);

    for (int i = 0; i < DEPTH; i++) preload(i, 8'(i));
    run_cmd("sum_full", 2'b10, 0, 0, DEPTH, 8'h00);
    check("sum_full value", result, 8'h00);

    for (int k = 0; k < 25; k++) begin
      op = $urandom_range(0, 3);
      r  = $urandom_range(0, 9);
      len = (r == 0) ? 0 : (r == 1) ? $urandom_range(200, 400) : $urandom_range(1, 24);
      run_cmd("rand", 2'(op), $urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1),
              len, 8'($urandom));
    end

    // Reset in the middle of an 8-byte FILL, after three writes have landed.
    wr_q.delete(); exp_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_dst = AW'('h050); cmd_len = (AW+1)'(8);
    cmd_data = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst ram_rw", ram_rw, 0);
    check("rst ready/busy", {cmd_ready, busy}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      ref_mem[AW'('h050 + i)] = 8'hC3;
      exp_q.push_back({AW'('h050 + i), 8'hC3});
    end
    exp_result = '0;
    r = 0;
    repeat (3) begin @(negedge clk); if (done) r++; end
    check("rst no_done", r, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst release outs", {cmd_ready, busy, done}, 3'b100);
    check("rst n_writes", wr_q.size(), exp_q.size());
    check("rst mem_diffs", mem_diffs(), 0);
    check("rst result", result, 0);
    run_cmd("fill_after_rst", 2'b00, 0, 'h058, 3, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_block_engine.md
Name: ram_block_engine

Overview:
- Initiator for the 8-bit single-port synchronous RAM interface (rw, addr, data_write, data_read with 1-cycle registered read).
- Accepts one command at a time and executes it autonomously on the RAM: FILL a region with a constant, COPY a region, or compute an 8-bit additive CHECKSUM of a region.
- Sits between the CPU/bus side and the RAM, offloading bulk memory operations.

Parameters:
- ram_width, 10, RAM address width; matches the RAM's ram_width; addresses wrap modulo 2**ram_width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on the edge where cmd_valid && cmd_ready.
- cmd_op  in  2  00 FILL, 01 COPY, 10 CHECKSUM, 11 reserved (no-op).
- cmd_src  in  ram_width  source start address (COPY, CHECKSUM).
- cmd_dst  in  ram_width  destination start address (FILL, COPY).
- cmd_len  in  ram_width+1  byte count, 0..2**ram_width.
- cmd_data  in  8  fill byte (FILL only).
- busy  out  1  high from the cycle after acceptance until done is asserted, inclusive of the done cycle.
- done  out  1  one-cycle completion pulse.
- result  out  8  checksum of the most recent CHECKSUM command.
- ram_rw  out  1  1 = write, 0 = read/hold; connects to RAM rw.
- ram_addr  out  ram_width  connects to RAM addr.
- ram_wdata  out  8  connects to RAM data_write.
- ram_rdata  in  8  connects to RAM data_read; valid the cycle after a read cycle.

Behaviour:
- Reset (async assert, sync release): state IDLE, cmd_ready=1, busy=0, done=0, result=0, ram_rw=0, ram_addr=0, ram_wdata=0. ram_rw must drop to 0 immediately on rst_n low; a reset mid-command abandons it, with no done pulse and no further RAM writes.
- Command fields are latched at acceptance; input changes while busy are ignored. cmd_valid while busy is not accepted.
- States: IDLE, FILL, CP_RD, CP_WR, SUM_RD, SUM_LAST, DONE.
- RAM outputs are Moore-style from registered state/counters; ram_rw=0 in every state except FILL and CP_WR.
- cmd_len=0 or op=11: IDLE -> DONE; no RAM access; result unchanged.
- FILL, len N: N consecutive cycles with ram_rw=1, ram_addr=dst+i, ram_wdata=cmd_data, i=0..N-1; then DONE. Throughput is 1 byte/cycle.
- COPY, len N: for each i, CP_RD (rw=0, addr=src+i), then CP_WR (rw=1, addr=dst+i, ram_wdata=ram_rdata), giving 2N cycles; then DONE. Copy is strictly ascending; overlapping regions with dst>src propagate already-written bytes, which is defined behaviour and not an error.
- CHECKSUM, len N: N SUM_RD cycles (rw=0, addr=src+i), with the accumulator adding ram_rdata one cycle later; then one SUM_LAST cycle adding the final byte; then DONE. result = sum mod 256, updated on entry to DONE. The accumulator clears at acceptance.
- DONE lasts exactly 1 cycle: done=1, then IDLE. cmd_ready reasserts the cycle after done.
- Latency from acceptance edge to done cycle: FILL N+1, COPY 2N+1, CHECKSUM N+2, zero-length 1.
- Address arithmetic wraps modulo 2**ram_width; no error on wrap. The length counter is ram_width+1 bits so the full RAM (len=2**ram_width) is legal.
- result holds its value across FILL, COPY and no-op commands.

Decomposition:
- Package ram_block_pkg holds the op encodings (OP_FILL, OP_COPY, OP_SUM, OP_NOP) and the state enumeration.
- Single flat module; no sub-module is needed. The bench instantiates the existing RAM as the responder.

Test Plan:
- FILL dst=0x010, len=4, data=0xA5 -> writes at 0x010..0x013 on 4 consecutive cycles; done on cycle 5 after acceptance; readback gives A5 A5 A5 A5.
- Preload 0x100..0x102 = 01 02 03; COPY src=0x100, dst=0x200, len=3 -> 0x200..0x202 = 01 02 03; done at cycle 7.
- Preload 0x300..0x303 = FF 01 10 20; CHECKSUM len=4 -> result=0x30; done at cycle 6. A following FILL leaves result=0x30.
- Wrap: FILL dst=0x3FE, len=4, data=0x5A -> writes 0x3FE, 0x3FF, 0x000, 0x001. Also len=0 -> done 1 cycle after acceptance, ram_rw never 1.
- Full-size: CHECKSUM src=0, len=1024 over a RAM holding addr[7:0] -> result=0x00; done at cycle 1026.
- Reset mid-FILL (len=8, rst_n low after 3 writes) -> ram_rw=0 immediately; only 3 bytes written; no done pulse; cmd_ready=1 after release.
